// File: rtl/beaten_pix_pattern_gen_pkg.sv
// Shared definitions for the beaten-pixel pattern generator: pattern codes,
// FSM encodings, LFSR constants and the saturation guard width.
package beaten_pix_pattern_gen_pkg;

  typedef enum logic [1:0] {
    PAT_FLAT  = 2'd0,
    PAT_HRAMP = 2'd1,
    PAT_VRAMP = 2'd2,
    PAT_NOISE = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_H_BLANK = 2'd2,
    ST_V_BLANK = 2'd3
  } state_e;

  // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci register: bits 0,2,3,5 feed bit 15.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  // Sums are formed one bit wider than the sample, then clamped to all-ones on carry.
  localparam int SAT_GUARD_BITS = 1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/beaten_pix_pattern_gen_if.sv
// Sample-side bus of the pattern generator: control inputs plus the
// dual-channel ADC-style sample stream seen by the beaten-pixel filter.
interface beaten_pix_pattern_gen_if #(
  parameter int ADC_WIDHT = 14
);
  logic                 run;
  logic [1:0]           pattern;
  logic [ADC_WIDHT-1:0] base_level;
  logic                 beat_en;
  logic [15:0]          beat_period;
  logic [ADC_WIDHT-1:0] beat_amplitude;

  logic                 clk_adc;
  logic [ADC_WIDHT-1:0] out_adc1;
  logic [ADC_WIDHT-1:0] out_adc2;
  logic                 enable;
  logic                 frame_start;
  logic                 beat_flag1;
  logic                 beat_flag2;

  modport master (
    input  run, pattern, base_level, beat_en, beat_period, beat_amplitude,
    output clk_adc, out_adc1, out_adc2, enable, frame_start, beat_flag1, beat_flag2
  );

  modport slave (
    output run, pattern, base_level, beat_en, beat_period, beat_amplitude,
    input  clk_adc, out_adc1, out_adc2, enable, frame_start, beat_flag1, beat_flag2
  );
endinterface

// File: rtl/beaten_pix_lfsr.sv
// 16-bit noise LFSR; seed reloads the start value, step advances one state.
// With both asserted the register holds the state following the seed.
module beaten_pix_lfsr
  import beaten_pix_pattern_gen_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             seed,
  input  logic             step,
  output logic [OUT_W-1:0] q
);
  logic [15:0] state;

  // NOTE: sequential state uses <= so every register in the design samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= LFSR_SEED;
    end else if (seed) begin
      state <= step ? lfsr_step(LFSR_SEED) : LFSR_SEED;
    end else if (step) begin
      state <= lfsr_step(state);
    end
  end

  assign q = state[OUT_W-1:0];

endmodule

// File: rtl/beaten_pix_pattern_gen.sv
// Synthetic dual-channel ADC source: framed 14-bit pixel pairs on a divided
// sample clock, with programmable injected defects and per-sample golden flags.
module beaten_pix_pattern_gen
  import beaten_pix_pattern_gen_pkg::*;
#(
  parameter int ADC_WIDHT    = 14,
  parameter int DIV          = 4,
  parameter int PIX_PER_LINE = 384,
  parameter int LINES        = 288,
  parameter int H_BLANK      = 16,
  parameter int V_BLANK      = 4
) (
  input logic                      CLK,
  input logic                      RST_N,
  beaten_pix_pattern_gen_if.master bus
);
  localparam int W          = ADC_WIDHT;
  localparam int VB_SAMPLES = V_BLANK * (PIX_PER_LINE + H_BLANK);
  localparam int PH_W       = $clog2(DIV);
  localparam int PIX_W      = $clog2(PIX_PER_LINE + 1);
  localparam int LINE_W     = $clog2(LINES + 1);
  localparam int BLK_W      = $clog2(VB_SAMPLES + H_BLANK + 1);

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W+SAT_GUARD_BITS-1:0] s;
    s = {{SAT_GUARD_BITS{1'b0}}, a} + {{SAT_GUARD_BITS{1'b0}}, b};
    return (s[W+SAT_GUARD_BITS-1:W] != '0) ? {W{1'b1}} : s[W-1:0];
  endfunction

  function automatic logic [W-1:0] sat_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a > b) ? a - b : '0;
  endfunction

  logic [PH_W-1:0]   ph;
  logic              tick;
  logic              clk_adc;
  state_e            state, state_nxt;
  logic              frame_start_nxt, active_nxt;
  logic [PIX_W-1:0]  pix, pix_s;
  logic [LINE_W-1:0] line, line_s;
  logic [BLK_W-1:0]  blk;
  logic [15:0]       beat_cnt, beat_cnt_nxt, cnt_s, period_q, period_s;
  logic              beat_idx, beat_idx_nxt, idx_s, hit, inject;
  pattern_e          pattern_q, pattern_s;
  logic [W-1:0]      base_q, base_s, term, clean1, clean2;
  logic [7:0]        lfsr_q, noise_s;
  logic [W-1:0]      adc1_nxt, adc2_nxt, adc1_q, adc2_q;
  logic              flag1_nxt, flag2_nxt, flag1_q, flag2_q, enable_q, frame_start_q;

  // tick marks the CLK edge on which CLK_ADC rises and a new sample is presented.
  assign tick = (ph == PH_W'(DIV - 1));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ph      <= '0;
      clk_adc <= 1'b0;
    end else begin
      ph <= tick ? '0 : ph + PH_W'(1);
      if (tick) clk_adc <= 1'b1;
      else if (ph == PH_W'(DIV / 2 - 1)) clk_adc <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= ST_IDLE;
    else if (tick) state <= state_nxt;
  end

  // RUN is only consulted when no frame is in flight, so a dropped RUN lets the frame finish.
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    state_nxt       = state;
    frame_start_nxt = 1'b0;
    case (state)
      ST_IDLE: if (bus.run) begin
        state_nxt       = ST_ACTIVE;
        frame_start_nxt = 1'b1;
      end
      ST_ACTIVE: if (pix == PIX_W'(PIX_PER_LINE - 1)) state_nxt = ST_H_BLANK;
      ST_H_BLANK: if (blk == BLK_W'(H_BLANK - 1))
        state_nxt = (line == LINE_W'(LINES - 1)) ? ST_V_BLANK : ST_ACTIVE;
      ST_V_BLANK: if (blk == BLK_W'(VB_SAMPLES - 1)) begin
        state_nxt       = bus.run ? ST_ACTIVE : ST_IDLE;
        frame_start_nxt = bus.run;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Everything below describes the sample about to be presented at the next tick.
  always_comb begin
    active_nxt = (state_nxt == ST_ACTIVE);
    pix_s      = (!frame_start_nxt && state == ST_ACTIVE) ? pix + PIX_W'(1) : '0;
    line_s     = line;
    if (frame_start_nxt) line_s = '0;
    else if (state == ST_H_BLANK) line_s = line + LINE_W'(1);

    pattern_s = frame_start_nxt ? pattern_e'(bus.pattern) : pattern_q;
    base_s    = frame_start_nxt ? bus.base_level : base_q;
    period_s  = frame_start_nxt ? bus.beat_period : period_q;
    noise_s   = frame_start_nxt ? LFSR_SEED[7:0] : lfsr_q;

    case (pattern_s)
      PAT_HRAMP: term = W'(pix_s);
      PAT_VRAMP: term = W'(line_s);
      PAT_NOISE: term = W'(noise_s);
      default:   term = '0;
    endcase
    clean1 = sat_add(base_s, term);
    clean2 = sat_add(clean1, W'(1));

    cnt_s        = frame_start_nxt ? '0 : beat_cnt;
    idx_s        = frame_start_nxt ? 1'b0 : beat_idx;
    hit          = (period_s != '0) && (cnt_s == period_s - 16'd1);
    inject       = hit && bus.beat_en;
    beat_cnt_nxt = hit ? '0 : cnt_s + 16'd1;
    beat_idx_nxt = inject ? !idx_s : idx_s;

    flag1_nxt = active_nxt && inject && !idx_s;
    flag2_nxt = active_nxt && inject && idx_s;
    adc1_nxt  = '0;
    adc2_nxt  = '0;
    if (active_nxt) begin
      adc1_nxt = flag1_nxt ? sat_add(clean1, bus.beat_amplitude) : clean1;
      adc2_nxt = flag2_nxt ? sat_sub(clean2, bus.beat_amplitude) : clean2;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pix       <= '0;
      line      <= '0;
      blk       <= '0;
      beat_cnt  <= '0;
      beat_idx  <= 1'b0;
      pattern_q <= PAT_FLAT;
      base_q    <= '0;
      period_q  <= '0;
    end else if (tick) begin
      blk <= (state_nxt == state && (state == ST_H_BLANK || state == ST_V_BLANK))
             ? blk + BLK_W'(1) : '0;
      if (active_nxt) begin
        pix      <= pix_s;
        line     <= line_s;
        beat_cnt <= beat_cnt_nxt;
        beat_idx <= beat_idx_nxt;
      end
      if (frame_start_nxt) begin
        pattern_q <= pattern_s;
        base_q    <= base_s;
        period_q  <= period_s;
      end
    end
  end

  beaten_pix_lfsr #(.OUT_W(8)) u_lfsr (
    .CLK   (CLK),
    .RST_N (RST_N),
    .seed  (tick && frame_start_nxt),
    .step  (tick && active_nxt),
    .q     (lfsr_q)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      frame_start_q <= 1'b0;
      enable_q      <= 1'b0;
      adc1_q        <= '0;
      adc2_q        <= '0;
      flag1_q       <= 1'b0;
      flag2_q       <= 1'b0;
    end else begin
      frame_start_q <= tick && frame_start_nxt;
      if (tick) begin
        enable_q <= active_nxt;
        adc1_q   <= adc1_nxt;
        adc2_q   <= adc2_nxt;
        flag1_q  <= flag1_nxt;
        flag2_q  <= flag2_nxt;
      end
    end
  end

  assign bus.clk_adc     = clk_adc;
  assign bus.out_adc1    = adc1_q;
  assign bus.out_adc2    = adc2_q;
  assign bus.enable      = enable_q;
  assign bus.frame_start = frame_start_q;
  assign bus.beat_flag1  = flag1_q;
  assign bus.beat_flag2  = flag2_q;

endmodule

// File: tb/tb_beaten_pix_pattern_gen.sv
// Self-checking bench for beaten_pix_pattern_gen: a frame model fills a
// scoreboard that is drained sample by sample as the generator emits frames.
module tb_beaten_pix_pattern_gen;
  localparam int AW   = 14;
  localparam int DIV  = 4;
  localparam int PPL  = 384;
  localparam int LN   = 2;
  localparam int HB   = 16;
  localparam int VB   = 2;
  localparam int LS   = PPL + HB;
  localparam int FRAME_SAMPLES = (LN + VB) * LS;
  localparam int MAXV = (1 << AW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  beaten_pix_pattern_gen_if #(.ADC_WIDHT(AW)) bus ();

  beaten_pix_pattern_gen #(
    .ADC_WIDHT(AW), .DIV(DIV), .PIX_PER_LINE(PPL),
    .LINES(LN), .H_BLANK(HB), .V_BLANK(VB)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic          act;
    logic          f1;
    logic          f2;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic adc_prev = 1'b0;

  always @(negedge clk) adc_prev <= bus.clk_adc;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  // Returns at the first negedge after CLK_ADC rises (one call per sample).
  task automatic wait_sample(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * DIV; i++) begin
      @(negedge clk);
      if (bus.clk_adc === 1'b1 && adc_prev === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic push_frame(input int pat, input int base, input bit ben, input int period, input int amp);
    logic [15:0] lf;
    int cnt, term, c1, c2, v1, v2;
    bit idx, f1, f2, hit, fb;
    exp_t e;
    lf = 16'hACE1;
    cnt = 0;
    idx = 1'b0;
    for (int ln = 0; ln < LN; ln++) begin
      for (int s = 0; s < LS; s++) begin
        e = '0;
        if (s < PPL) begin
          case (pat)
            0: term = 0;
            1: term = s;
            2: term = ln;
            default: term = int'(lf[7:0]);
          endcase
          c1 = sat(base + term);
          c2 = sat(c1 + 1);
          v1 = c1;
          v2 = c2;
          f1 = 1'b0;
          f2 = 1'b0;
          hit = (period != 0) && (cnt == period - 1);
          cnt = hit ? 0 : cnt + 1;
          if (hit && ben) begin
            if (!idx) begin
              v1 = sat(c1 + amp);
              f1 = 1'b1;
            end else begin
              v2 = (c2 > amp) ? c2 - amp : 0;
              f2 = 1'b1;
            end
            idx = !idx;
          end
          fb = lf[0] ^ lf[2] ^ lf[3] ^ lf[5];
          lf = {fb, lf[15:1]};
          e.act = 1'b1;
          e.f1 = f1;
          e.f2 = f2;
          e.a1 = v1[AW-1:0];
          e.a2 = v2[AW-1:0];
        end
        sb.push_back(e);
      end
    end
  endtask

  task automatic capture_frame(input string tag, input int drop_at);
    bit ok, found;
    exp_t e;
    logic exp_fs;
    found = 1'b0;
    for (int i = 0; i < 3 * FRAME_SAMPLES; i++) begin
      wait_sample(ok);
      if (!ok) break;
      if (bus.frame_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s frame_start_timeout: got none, required a frame start", tag);
      sb.delete();
      return;
    end
    for (int k = 0; k < LN * LS; k++) begin
      if (k > 0) begin
        wait_sample(ok);
        if (!ok) begin
          checks++;
          errors++;
          $display("FAIL %s clk_adc_stalled at sample %0d: got no CLK_ADC edge, required one", tag, k);
          sb.delete();
          return;
        end
      end
      if (k == drop_at) bus.run = 1'b0;
      e = sb.pop_front();
      exp_fs = (k == 0);
      checks++;
      if (bus.enable !== e.act) begin
        errors++;
        $display("FAIL %s enable line %0d s %0d: got %b, expected %b", tag, k / LS, k % LS, bus.enable, e.act);
      end
      checks++;
      if (bus.out_adc1 !== e.a1) begin
        errors++;
        $display("FAIL %s adc1 line %0d s %0d: got %0d, expected %0d", tag, k / LS, k % LS, bus.out_adc1, e.a1);
      end
      checks++;
      if (bus.out_adc2 !== e.a2) begin
        errors++;
        $display("FAIL %s adc2 line %0d s %0d: got %0d, expected %0d", tag, k / LS, k % LS, bus.out_adc2, e.a2);
      end
      checks++;
      if (bus.beat_flag1 !== e.f1 || bus.beat_flag2 !== e.f2) begin
        errors++;
        $display("FAIL %s flags line %0d s %0d: got %b%b, expected %b%b", tag, k / LS, k % LS,
                 bus.beat_flag1, bus.beat_flag2, e.f1, e.f2);
      end
      checks++;
      if (bus.frame_start !== exp_fs) begin
        errors++;
        $display("FAIL %s frame_start line %0d s %0d: got %b, expected %b", tag, k / LS, k % LS, bus.frame_start, exp_fs);
      end
    end
  endtask

  task automatic set_inputs(input int pat, input int base, input bit ben, input int period, input int amp);
    bus.pattern        = pat[1:0];
    bus.base_level     = base[AW-1:0];
    bus.beat_en        = ben;
    bus.beat_period    = period[15:0];
    bus.beat_amplitude = amp[AW-1:0];
  endtask

  task automatic check_first_sample(input string tag, input int a1, input int a2);
    int lat;
    lat = 0;
    for (int i = 0; i < 3 * DIV && bus.enable !== 1'b1; i++) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (bus.enable !== 1'b1 || lat > DIV + 1) begin
      errors++;
      $display("FAIL %s first_enable_latency: got %0d cycles (enable=%b), required <= %0d", tag, lat, bus.enable, DIV + 1);
    end
    checks++;
    if (bus.frame_start !== 1'b1) begin
      errors++;
      $display("FAIL %s first_frame_start: got %b, expected 1", tag, bus.frame_start);
    end
    checks++;
    if (bus.out_adc1 !== AW'(a1) || bus.out_adc2 !== AW'(a2)) begin
      errors++;
      $display("FAIL %s first_sample: got %0d/%0d, expected %0d/%0d", tag, bus.out_adc1, bus.out_adc2, a1, a2);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if (bus.clk_adc !== 1'b0 || bus.enable !== 1'b0 || bus.frame_start !== 1'b0 ||
        bus.beat_flag1 !== 1'b0 || bus.beat_flag2 !== 1'b0 || bus.out_adc1 !== '0 || bus.out_adc2 !== '0) begin
      errors++;
      $display("FAIL %s outputs_zero: got clk_adc=%b en=%b fs=%b f=%b%b adc=%0d/%0d, expected all 0", tag,
               bus.clk_adc, bus.enable, bus.frame_start, bus.beat_flag1, bus.beat_flag2, bus.out_adc1, bus.out_adc2);
    end
  endtask

  task automatic test_reset();
    bus.run = 1'b1;
    set_inputs(1, 100, 1'b0, 0, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_outputs_zero("reset_hold");
    end
    rst_n = 1'b1;
    check_first_sample("reset_release", 100, 101);
  endtask

  task automatic test_hramp();
    set_inputs(1, 100, 1'b0, 0, 0);
    push_frame(1, 100, 1'b0, 0, 0);
    capture_frame("hramp", -1);
  endtask

  task automatic test_saturation();
    set_inputs(1, 16380, 1'b0, 0, 0);
    push_frame(1, 16380, 1'b0, 0, 0);
    capture_frame("saturation", -1);
  endtask

  task automatic test_defects();
    set_inputs(0, 1000, 1'b1, 10, 500);
    push_frame(0, 1000, 1'b1, 10, 500);
    capture_frame("defects", -1);
  endtask

  task automatic test_floor();
    set_inputs(0, 1000, 1'b1, 10, 2000);
    push_frame(0, 1000, 1'b1, 10, 2000);
    capture_frame("floor", -1);
  endtask

  task automatic test_vramp();
    set_inputs(2, 50, 1'b1, 37, 300);
    push_frame(2, 50, 1'b1, 37, 300);
    capture_frame("vramp", -1);
  endtask

  task automatic test_noise();
    set_inputs(3, 200, 1'b0, 5, 100);
    push_frame(3, 200, 1'b0, 5, 100);
    capture_frame("noise", -1);
  endtask

  task automatic test_run_drop();
    bit ok;
    set_inputs(1, 7, 1'b0, 0, 0);
    push_frame(1, 7, 1'b0, 0, 0);
    capture_frame("run_drop", 150);
    for (int i = 0; i < VB * LS + 2 * LS; i++) begin
      wait_sample(ok);
      checks++;
      if (!ok || bus.enable !== 1'b0 || bus.frame_start !== 1'b0 || bus.out_adc1 !== '0 ||
          bus.out_adc2 !== '0 || bus.beat_flag1 !== 1'b0 || bus.beat_flag2 !== 1'b0) begin
        errors++;
        $display("FAIL run_drop_blank_idle sample %0d: got ok=%b en=%b fs=%b adc=%0d/%0d, expected quiet", i,
                 ok, bus.enable, bus.frame_start, bus.out_adc1, bus.out_adc2);
      end
    end
    @(negedge clk);
    bus.run = 1'b1;
    check_first_sample("run_restart", 7, 8);
  endtask

  task automatic test_reset_mid_line();
    bit ok;
    for (int i = 0; i < 50; i++) wait_sample(ok);
    @(negedge clk);
    checks++;
    if (bus.enable !== 1'b1 || bus.out_adc1 !== AW'(57)) begin
      errors++;
      $display("FAIL reset_mid_precondition: got en=%b adc1=%0d, expected 1/57", bus.enable, bus.out_adc1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset_mid_line");
    @(negedge clk);
    check_outputs_zero("reset_mid_line_hold");
    rst_n = 1'b1;
    check_first_sample("reset_mid_restart", 7, 8);
  endtask

  initial begin
    test_reset();
    test_hramp();
    test_saturation();
    test_defects();
    test_floor();
    test_vramp();
    test_noise();
    test_run_drop();
    test_reset_mid_line();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
